// File: rtl/ans_pkg.sv
// Shared types and helpers for the ANS probability-table blocks.
// Holds the controller state enum, default table geometry and the context/symbol index map.
package ans_pkg;

    localparam int ANS_NUM_CONTEXTS = 16;
    localparam int ANS_NUM_SYMBOLS  = 16;
    localparam int ANS_IDX_WIDTH    = $clog2(ANS_NUM_CONTEXTS * ANS_NUM_SYMBOLS);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ans_state_e;

    // Out-of-range context or symbol folds to 0 so a bad index never aliases another row.
    function automatic int unsigned ans_map_index(
        input int unsigned ctx,
        input int unsigned sym,
        input int unsigned num_contexts,
        input int unsigned num_symbols
    );
        int unsigned c;
        int unsigned s;
        c = (ctx >= num_contexts) ? 32'd0 : ctx;
        s = (sym >= num_symbols) ? 32'd0 : sym;
        return c * num_symbols + s;
    endfunction

endpackage

// File: rtl/ans_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Returns a one-hot grant, its encoded index and an any-grant flag.
module ans_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    int                  sum;
    logic [ID_WIDTH-1:0] lane;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = 0;
        lane      = '0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sum = int'(ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                lane = ID_WIDTH'(sum);
                if (!grant_any && req[lane]) begin
                    grant[lane] = 1'b1;
                    grant_idx   = lane;
                    grant_any   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ans_prob_table_ctrl.sv
// Shared context-indexed probability table: self-initialising, round-robin lane reads,
// configuration writes take priority over lane reads.
//
// state | meaning
// INIT  | table[idx] = idx written one entry per cycle, lanes and cfg writes held off
// RUN   | cfg write if cfg_we, else one round-robin lane lookup per cycle
module ans_prob_table_ctrl
    import ans_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CONTEXT_WIDTH = 4,
    parameter int SYMBOL_WIDTH  = 4,
    parameter int PROB_WIDTH    = 8,
    parameter int NUM_CONTEXTS  = ANS_NUM_CONTEXTS,
    parameter int NUM_SYMBOLS   = ANS_NUM_SYMBOLS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*CONTEXT_WIDTH-1:0]   req_ctx,
    input  logic [NUM_REQ*SYMBOL_WIDTH-1:0]    req_sym,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]         resp_id,
    output logic [PROB_WIDTH-1:0]              resp_prob,
    input  logic                               cfg_we,
    input  logic [CONTEXT_WIDTH-1:0]           cfg_ctx,
    input  logic [SYMBOL_WIDTH-1:0]            cfg_sym,
    input  logic [PROB_WIDTH-1:0]              cfg_data,
    output logic                               cfg_ack,
    output logic                               init_busy
);

    localparam int TABLE_DEPTH = NUM_CONTEXTS * NUM_SYMBOLS;
    localparam int IDX_WIDTH   = $clog2(TABLE_DEPTH);
    localparam int ID_WIDTH    = $clog2(NUM_REQ);

    ans_state_e            state, state_nxt;
    logic [IDX_WIDTH-1:0]  init_idx, init_idx_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic                  cfg_ack_nxt;

    logic                  arb_en;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_any;

    logic [CONTEXT_WIDTH-1:0] sel_ctx;
    logic [SYMBOL_WIDTH-1:0]  sel_sym;
    logic [IDX_WIDTH-1:0]     cfg_addr, rd_addr, tab_addr;
    logic                     tab_we, tab_re;
    logic [PROB_WIDTH-1:0]    tab_wdata;

    logic [PROB_WIDTH-1:0]    prob_table [TABLE_DEPTH];

    // Config writes own the single table port, so they blank every grant that cycle.
    assign arb_en    = (state == RUN) && !cfg_we;
    assign req_ready = grant;
    assign init_busy = (state == INIT);

    ans_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_ctx = '0;
        sel_sym = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_ctx = req_ctx[i*CONTEXT_WIDTH +: CONTEXT_WIDTH];
                sel_sym = req_sym[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
            end
        end
    end

    assign rd_addr  = IDX_WIDTH'(ans_map_index(32'(sel_ctx), 32'(sel_sym),
                                               NUM_CONTEXTS, NUM_SYMBOLS));
    assign cfg_addr = IDX_WIDTH'(ans_map_index(32'(cfg_ctx), 32'(cfg_sym),
                                               NUM_CONTEXTS, NUM_SYMBOLS));

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        rr_ptr_nxt   = rr_ptr;
        cfg_ack_nxt  = 1'b0;
        tab_we       = 1'b0;
        tab_re       = 1'b0;
        tab_addr     = rd_addr;
        tab_wdata    = '0;
        case (state)
            INIT: begin
                tab_we    = 1'b1;
                tab_addr  = init_idx;
                tab_wdata = PROB_WIDTH'(init_idx);
                if (init_idx == IDX_WIDTH'(TABLE_DEPTH - 1)) begin
                    state_nxt = RUN;
                end else begin
                    init_idx_nxt = init_idx + 1'b1;
                end
            end
            RUN: begin
                if (cfg_we) begin
                    tab_we      = 1'b1;
                    tab_addr    = cfg_addr;
                    tab_wdata   = cfg_data;
                    cfg_ack_nxt = 1'b1;
                end else if (grant_any) begin
                    tab_re     = 1'b1;
                    tab_addr   = rd_addr;
                    rr_ptr_nxt = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                       : grant_idx + 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= INIT;
            init_idx   <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            cfg_ack    <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_idx   <= init_idx_nxt;
            rr_ptr     <= rr_ptr_nxt;
            resp_valid <= tab_re;
            cfg_ack    <= cfg_ack_nxt;
            if (tab_re) begin
                resp_id <= grant_idx;
            end
        end
    end

    // Storage itself is never reset; only INIT restores the default contents.
    always_ff @(posedge clk) begin
        if (rst_n && tab_we) begin
            prob_table[tab_addr] <= tab_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_prob <= '0;
        end else if (tab_re) begin
            resp_prob <= prob_table[tab_addr];
        end
    end

endmodule

// File: tb/tb_ans_prob_table_ctrl.sv
// Bench for ans_prob_table_ctrl: directed scenarios plus randomized traffic against a table/pointer model.
// A second instance with 12 contexts covers out-of-range context folding.
module tb_ans_prob_table_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_ctx, req_sym;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [7:0]  resp_prob;
    logic        cfg_we;
    logic [3:0]  cfg_ctx, cfg_sym;
    logic [7:0]  cfg_data;
    logic        cfg_ack, init_busy;

    logic [3:0]  req_valid_b;
    logic [15:0] req_ctx_b, req_sym_b;
    logic [3:0]  req_ready_b;
    logic        resp_valid_b;
    logic [1:0]  resp_id_b;
    logic [7:0]  resp_prob_b;
    logic        cfg_we_b;
    logic [3:0]  cfg_ctx_b, cfg_sym_b;
    logic [7:0]  cfg_data_b;
    logic        cfg_ack_b, init_busy_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_tab [256];
    int         m_ptr;
    bit         m_run;

    logic [3:0] obs_ready, exp_ready;
    logic       obs_rv, exp_rv, obs_ack, exp_ack, obs_busy;
    logic [1:0] obs_rid, exp_rid;
    logic [7:0] obs_prob, exp_prob;

    always #5 clk = ~clk;

    ans_prob_table_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ctx(req_ctx), .req_sym(req_sym), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_prob(resp_prob),
        .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_sym(cfg_sym), .cfg_data(cfg_data),
        .cfg_ack(cfg_ack), .init_busy(init_busy)
    );

    ans_prob_table_ctrl #(.NUM_CONTEXTS(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ctx(req_ctx_b), .req_sym(req_sym_b), .req_ready(req_ready_b),
        .resp_valid(resp_valid_b), .resp_id(resp_id_b), .resp_prob(resp_prob_b),
        .cfg_we(cfg_we_b), .cfg_ctx(cfg_ctx_b), .cfg_sym(cfg_sym_b), .cfg_data(cfg_data_b),
        .cfg_ack(cfg_ack_b), .init_busy(init_busy_b)
    );

    function automatic int map_idx(input int c, input int s, input int nc, input int ns);
        int cc = (c >= nc) ? 0 : c;
        int ss = (s >= ns) ? 0 : s;
        return cc * ns + ss;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 256; i++) m_tab[i] = 8'(i);
        m_ptr = 0;
        m_run = 1'b1;
    endtask

    // One clock of traffic on the main instance; records observed and model-predicted values.
    task automatic cycle(input logic [3:0] v, input logic [15:0] c, input logic [15:0] s,
                         input logic we, input logic [3:0] cc, input logic [3:0] cs,
                         input logic [7:0] cd);
        int lane = -1;
        @(negedge clk);
        req_valid = v; req_ctx = c; req_sym = s;
        cfg_we = we; cfg_ctx = cc; cfg_sym = cs; cfg_data = cd;
        #1;
        obs_ready = req_ready;
        exp_ready = '0; exp_rv = 1'b0; exp_ack = 1'b0; exp_rid = '0; exp_prob = '0;
        if (m_run) begin
            if (we) begin
                m_tab[map_idx(int'(cc), int'(cs), 16, 16)] = cd;
                exp_ack = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (lane < 0 && v[(m_ptr + k) % 4]) lane = (m_ptr + k) % 4;
            end
            if (lane >= 0) begin
                exp_ready[lane] = 1'b1;
                exp_rv   = 1'b1;
                exp_rid  = 2'(lane);
                exp_prob = m_tab[map_idx(int'(c[lane*4 +: 4]), int'(s[lane*4 +: 4]), 16, 16)];
                m_ptr    = (lane + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        obs_rv = resp_valid; obs_rid = resp_id; obs_prob = resp_prob;
        obs_ack = cfg_ack; obs_busy = init_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_ctx = '0; req_sym = '0; cfg_we = 1'b0; cfg_ctx = '0; cfg_sym = '0; cfg_data = '0;
        req_valid_b = '0; req_ctx_b = '0; req_sym_b = '0; cfg_we_b = 1'b0; cfg_ctx_b = '0; cfg_sym_b = '0; cfg_data_b = '0;
        m_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%h want=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp_id got=%0d want=0", resp_id); end
        checks++; if (resp_prob !== 8'h00) begin failures++; $display("FAIL reset_resp_prob got=%h want=00", resp_prob); end
        checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL reset_cfg_ack got=%b want=0", cfg_ack); end
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_init_busy got=%b want=1", init_busy); end
        checks++; if (init_busy_b !== 1'b1) begin failures++; $display("FAIL reset_init_busy_b got=%b want=1", init_busy_b); end
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            cycle(4'($urandom), 16'($urandom), 16'($urandom), 1'b0, 4'd0, 4'd0, 8'd0);
            checks++; if (obs_ready !== 4'b0) begin failures++; $display("FAIL init_ready k=%0d got=%h want=0", k, obs_ready); end
            checks++; if (obs_busy !== (k < 256)) begin failures++; $display("FAIL init_busy k=%0d got=%b want=%b", k, obs_busy, k < 256); end
            if (k == 191 || k == 192) begin
                checks++; if (init_busy_b !== (k < 192)) begin failures++; $display("FAIL init_busy_b k=%0d got=%b want=%b", k, init_busy_b, k < 192); end
            end
        end
        model_init();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            cycle(4'hF, 16'($urandom), 16'($urandom), 1'b0, 4'd0, 4'd0, 8'd0);
            checks++; if (obs_ready !== seq[k]) begin failures++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, obs_ready, seq[k]); end
            checks++; if (obs_rv !== 1'b1 || obs_rid !== 2'(k % 4)) begin failures++; $display("FAIL rr_resp k=%0d got=%b/%0d want=1/%0d", k, obs_rv, obs_rid, k % 4); end
            checks++; if (obs_prob !== exp_prob) begin failures++; $display("FAIL rr_prob k=%0d got=%h want=%h", k, obs_prob, exp_prob); end
        end
        cycle(4'h0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_rv !== 1'b0) begin failures++; $display("FAIL rr_idle_valid got=%b want=0", obs_rv); end
    endtask

    task automatic test_read_default();
        cycle(4'b0010, 16'h0030, 16'h0050, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_ready !== 4'b0010) begin failures++; $display("FAIL rd_ready got=%b want=0010", obs_ready); end
        checks++; if (obs_rv !== 1'b1 || obs_rid !== 2'd1) begin failures++; $display("FAIL rd_resp got=%b/%0d want=1/1", obs_rv, obs_rid); end
        checks++; if (obs_prob !== 8'h35) begin failures++; $display("FAIL rd_prob got=%h want=35", obs_prob); end
        cycle(4'h0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_rv !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b want=0", obs_rv); end
    endtask

    task automatic test_write_then_read();
        cycle(4'b0010, 16'h0020, 16'h0010, 1'b1, 4'd2, 4'd1, 8'hA7);
        checks++; if (obs_ready !== 4'b0) begin failures++; $display("FAIL wr_ready got=%b want=0000", obs_ready); end
        checks++; if (obs_ack !== 1'b1 || obs_rv !== 1'b0) begin failures++; $display("FAIL wr_ack got=%b/%b want=1/0", obs_ack, obs_rv); end
        cycle(4'b0010, 16'h0020, 16'h0010, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_ready !== 4'b0010) begin failures++; $display("FAIL wr_rd_ready got=%b want=0010", obs_ready); end
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b want=0", obs_ack); end
        checks++; if (obs_rv !== 1'b1 || obs_rid !== 2'd1 || obs_prob !== 8'hA7) begin failures++; $display("FAIL wr_rd_data got=%b/%0d/%h want=1/1/a7", obs_rv, obs_rid, obs_prob); end
    endtask

    task automatic test_ctx_clamp();
        @(negedge clk);
        req_valid_b = 4'b0001; req_ctx_b = 16'h000E; req_sym_b = 16'h0009;
        #1;
        checks++; if (req_ready_b !== 4'b0001) begin failures++; $display("FAIL clamp_ready got=%b want=0001", req_ready_b); end
        @(posedge clk); #1;
        checks++; if (resp_valid_b !== 1'b1 || resp_prob_b !== 8'h09) begin failures++; $display("FAIL clamp_rd got=%b/%h want=1/09", resp_valid_b, resp_prob_b); end
        @(negedge clk);
        req_valid_b = 4'b0; cfg_we_b = 1'b1; cfg_ctx_b = 4'd13; cfg_sym_b = 4'd2; cfg_data_b = 8'h5C;
        @(posedge clk); #1;
        checks++; if (cfg_ack_b !== 1'b1) begin failures++; $display("FAIL clamp_ack got=%b want=1", cfg_ack_b); end
        @(negedge clk);
        cfg_we_b = 1'b0; req_valid_b = 4'b0010; req_ctx_b = 16'h0000; req_sym_b = 16'h0020;
        #1;
        checks++; if (req_ready_b !== 4'b0010) begin failures++; $display("FAIL clamp_ready2 got=%b want=0010", req_ready_b); end
        @(posedge clk); #1;
        checks++; if (resp_prob_b !== 8'h5C || resp_id_b !== 2'd1) begin failures++; $display("FAIL clamp_wr_rd got=%h/%0d want=5c/1", resp_prob_b, resp_id_b); end
        @(negedge clk);
        req_valid_b = 4'b0100; req_ctx_b = 16'h0B00; req_sym_b = 16'h0300;
        @(posedge clk); #1;
        checks++; if (resp_prob_b !== 8'hB3 || resp_id_b !== 2'd2) begin failures++; $display("FAIL clamp_last_ctx got=%h/%0d want=b3/2", resp_prob_b, resp_id_b); end
        @(negedge clk);
        req_valid_b = 4'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle(4'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 6) == 0),
                  4'($urandom), 4'($urandom), 8'($urandom));
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_ready k=%0d got=%b want=%b", k, obs_ready, exp_ready); end
            checks++; if (obs_ack !== exp_ack) begin failures++; $display("FAIL rand_ack k=%0d got=%b want=%b", k, obs_ack, exp_ack); end
            checks++; if (obs_rv !== exp_rv) begin failures++; $display("FAIL rand_valid k=%0d got=%b want=%b", k, obs_rv, exp_rv); end
            if (exp_rv) begin
                checks++; if (obs_rid !== exp_rid || obs_prob !== exp_prob) begin failures++; $display("FAIL rand_resp k=%0d got=%0d/%h want=%0d/%h", k, obs_rid, obs_prob, exp_rid, exp_prob); end
            end
        end
    endtask

    task automatic test_cfg_during_init();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; cfg_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_run = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            cycle(4'($urandom), 16'($urandom), 16'($urandom), 1'b1, 4'd4, 4'd4, 8'hEE);
            checks++; if (obs_ack !== 1'b0 || obs_ready !== 4'b0) begin failures++; $display("FAIL init_cfg k=%0d got=%b/%b want=0/0000", k, obs_ack, obs_ready); end
            if (k >= 255) begin
                checks++; if (obs_busy !== (k < 256)) begin failures++; $display("FAIL init_cfg_busy k=%0d got=%b want=%b", k, obs_busy, k < 256); end
            end
        end
        model_init();
        cycle(4'hF, 16'($urandom), 16'($urandom), 1'b1, 4'd4, 4'd4, 8'hEE);
        checks++; if (obs_ready !== 4'b0 || obs_ack !== 1'b1) begin failures++; $display("FAIL init_cfg_commit got=%b/%b want=0000/1", obs_ready, obs_ack); end
        cycle(4'b0001, 16'h0004, 16'h0004, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_rv !== 1'b1 || obs_prob !== 8'hEE) begin failures++; $display("FAIL init_cfg_rd got=%b/%h want=1/ee", obs_rv, obs_prob); end
    endtask

    task automatic test_reset_midflight();
        cycle(4'h0, 16'h0, 16'h0, 1'b1, 4'd5, 4'd6, 8'h11);
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL mid_wr_ack got=%b want=1", obs_ack); end
        @(negedge clk);
        req_valid = 4'b0100; req_ctx = 16'h0500; req_sym = 16'h0600; cfg_we = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || init_busy !== 1'b1) begin failures++; $display("FAIL mid_reset got=%b/%b want=0/1", resp_valid, init_busy); end
        rst_n = 1'b1;
        m_run = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            cycle(4'b0100, 16'h0500, 16'h0600, 1'b0, 4'd0, 4'd0, 8'd0);
            if (k == 1) begin
                checks++; if (obs_rv !== 1'b0) begin failures++; $display("FAIL mid_init_valid got=%b want=0", obs_rv); end
            end
        end
        checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL mid_init_done got=%b want=0", obs_busy); end
        model_init();
        cycle(4'b0100, 16'h0500, 16'h0600, 1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (obs_ready !== 4'b0100 || obs_rid !== 2'd2 || obs_prob !== 8'h56) begin failures++; $display("FAIL mid_default got=%b/%0d/%h want=0100/2/56", obs_ready, obs_rid, obs_prob); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_default();
        test_write_then_read();
        test_ctx_clamp();
        test_random();
        test_cfg_during_init();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing the test sequence");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ans_prob_table_ctrl.md
# ans_prob_table_ctrl

Controller and arbiter for the ANS decoder's shared context-indexed probability table. It owns a single-ported table of NUM_CONTEXTS×NUM_SYMBOLS entries and initialises it after reset. It shares read access round-robin among NUM_REQ decoder lanes and accepts table updates from a configuration port that has priority over lane reads. It sits between the ANS lane decoders and the probability storage, replacing per-lane static lookup.

## Interface
- NUM_REQ, 4, number of requesting decoder lanes
- CONTEXT_WIDTH, 4, context index width
- SYMBOL_WIDTH, 4, symbol index width
- PROB_WIDTH, 8, probability entry width
- NUM_CONTEXTS, 16, valid contexts (≤ 2^CONTEXT_WIDTH)
- NUM_SYMBOLS, 16, valid symbols (≤ 2^SYMBOL_WIDTH)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-lane lookup request
- req_ctx  in  NUM_REQ×CONTEXT_WIDTH  per-lane context
- req_sym  in  NUM_REQ×SYMBOL_WIDTH  per-lane symbol
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready
- resp_valid  out  1  lookup result valid
- resp_id  out  $clog2(NUM_REQ)  lane that owns the result
- resp_prob  out  PROB_WIDTH  table entry
- cfg_we  in  1  table write request
- cfg_ctx  in  CONTEXT_WIDTH  write context
- cfg_sym  in  SYMBOL_WIDTH  write symbol
- cfg_data  in  PROB_WIDTH  write data
- cfg_ack  out  1  one-cycle pulse, write committed
- init_busy  out  1  table initialisation in progress

## Operation
- FSM states are INIT and RUN. Reset forces INIT with init index 0 and round-robin pointer 0.
- INIT:
  - Each cycle writes table[idx] = idx[PROB_WIDTH-1:0], where idx = ctx*NUM_SYMBOLS+sym.
  - idx increments each cycle. After writing idx = NUM_CONTEXTS*NUM_SYMBOLS-1, the FSM moves to RUN.
  - req_ready is all zero and cfg_we is ignored, with no ack. A write presented during INIT must be held until init_busy=0.
- RUN, priority order:
  - If cfg_we=1, write table[map(cfg_ctx,cfg_sym)] = cfg_data. req_ready is all zero that cycle. cfg_ack=1 next cycle.
  - Else, if any req_valid, grant the first set bit at or after the rr pointer (wrapping). req_ready has exactly that bit set. The pointer becomes granted+1 mod NUM_REQ.
  - Else, no action and the pointer is held.
- req_ready is combinational from req_valid, cfg_we and state. Lanes must not make req_valid depend on req_ready.
- Address mapping (map):
  - ctx ≥ NUM_CONTEXTS → ctx 0
  - sym ≥ NUM_SYMBOLS → sym 0
  - Applies to both reads and cfg writes.
- Table entries are not cleared by reset except via INIT.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_id 0, resp_prob 0, cfg_ack 0, init_busy 1.
- INIT length is exactly NUM_CONTEXTS*NUM_SYMBOLS cycles after the first cycle with rst_n=1. For defaults that is 256.
  - init_busy deasserts on the edge that completes the last write.
  - The first grant is possible in cycle 256.
- Read latency is 1. A request accepted at edge t gives resp_valid=1 with resp_id and resp_prob in cycle t+1, and resp_valid is high for exactly one cycle.
- Back-to-back grants give one response per cycle. Throughput is 1 lookup/cycle shared across lanes.
- Write-then-read: a cfg write at edge t followed by a granted read at edge t+1 returns the new data. Same-cycle conflict is impossible because the cfg write blocks grants.
- cfg_ack is high in cycle t+1 for a write accepted at edge t. Sustained cfg_we starves lanes by design.
- Reset mid-operation:
  - Any in-flight response is dropped; resp_valid is 0 next cycle.
  - The FSM returns to INIT and restarts at idx 0, overwriting all cfg updates.

## Structure
- Package ans_pkg holds:
  - the state enum (INIT, RUN)
  - the flat-index width localparam $clog2(NUM_CONTEXTS*NUM_SYMBOLS)
  - an index function implementing map
- Sub-module ans_rr_arbiter takes NUM_REQ request bits, the pointer and an enable, and returns a one-hot grant plus the encoded index. It is reusable by other shared ANS resources.
- The table is an inferred single-port array with registered read; there is no separate RAM wrapper.

## Test plan
- Reset, then hold idle → init_busy=1 for 256 cycles, then 0. Read ctx 3 sym 5 → resp_prob=0x35 one cycle after grant.
- All 4 lanes valid continuously with pointer 0 → grants go 0,1,2,3,0. resp_id follows the grant, one cycle later.
- cfg write ctx 2 sym 1 data 0xA7, then lane 1 reads ctx 2 sym 1 the next cycle → cfg_ack pulses, req_ready is 0 in the write cycle, and the read returns 0xA7.
- With NUM_CONTEXTS=12, a lane reads ctx 14 sym 9 → resp_prob=0x09 (mapped to ctx 0).
- cfg_we held during INIT → no ack and no write. The write is committed on the first RUN cycle, with ack the following cycle.
- rst_n low for one cycle while lane 2's response is pending → resp_valid=0, init_busy=1, and the earlier cfg update is replaced by the default after INIT completes.
